seq_mult_signed_n: RTL and testbench

//  Parametrised sequential shift-add multiplier with start/busy/done handshake and selectable

---
 rtl/seq_mult_signed_n.sv | 59 +++++
 tb/tb_seq_mult_signed_n.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_signed_n.sv
// seq_mult_signed_n: shift-add multiplier, one multiplier bit per clock, signed or unsigned
module seq_mult_signed_n #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] acc, mcand, mplier, mag_a, mag_b;
  logic [WIDTH:0] sum;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] prod;
  logic neg, load;
  always_comb begin
    load = start && (state == IDLE || state == DONE);
    state_n = load ? RUN :
              state == RUN ? (cnt == CW'(1) ? SIGN : RUN) :
              state == SIGN ? DONE : IDLE;
    mag_a = (signed_mode && a[WIDTH-1]) ? -a : a;
    mag_b = (signed_mode && b[WIDTH-1]) ? -b : b;
    sum = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
    prod = {acc, mplier};
  end
  assign busy = state == RUN || state == SIGN;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        acc    <= '0;
        mcand  <= mag_a;
        mplier <= mag_b;
        cnt    <= CW'(WIDTH);
        neg    <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (state == RUN) begin
        {acc, mplier} <= {sum, mplier[WIDTH-1:1]};
        cnt <= cnt - CW'(1);
      end
      if (state == SIGN) result <= neg ? -prod : prod;
    end
  end
endmodule

// File: tb/tb_seq_mult_signed_n.sv
// tb_seq_mult_signed_n: randomized and directed checks of the multiplier at WIDTH 8 and 16
module tb_seq_mult_signed_n;
  logic clk = 1'b0, rst = 1'b1;
  logic start8 = 1'b0, sm8 = 1'b0, busy8, done8;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] res8;
  logic start16 = 1'b0, sm16 = 1'b0, busy16, done16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] res16;
  int pass = 0, total = 0;

  always #5 clk = ~clk;

  seq_mult_signed_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8));

  seq_mult_signed_n #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(res16));

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
    longint px = s ? longint'($signed(x)) : longint'(x);
    longint py = s ? longint'($signed(y)) : longint'(y);
    return 16'(px * py);
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic s);
    longint px = s ? longint'($signed(x)) : longint'(x);
    longint py = s ? longint'($signed(y)) : longint'(y);
    return 32'(px * py);
  endfunction

  // Issues one op on the 8-bit DUT, scrambles inputs after acceptance, waits for done.
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                     output logic [15:0] r, output int lat, output int bcnt);
    @(negedge clk);
    a8 = ia; b8 = ib; sm8 = is; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    lat = 0; bcnt = 0;
    while (!done8 && lat < 40) begin
      bcnt += int'(busy8);
      @(negedge clk);
      lat++;
    end
    r = res8;
  endtask

  task automatic check_op8(input string name, input logic [7:0] ia, input logic [7:0] ib,
                           input logic is);
    logic [15:0] r, e;
    int lat, bcnt;
    e = ref8(ia, ib, is);
    op8(ia, ib, is, r, lat, bcnt);
    total++;
    if (r !== e) $display("FAIL %s result a=%h b=%h s=%0d got %h exp %h", name, ia, ib, is, r, e);
    else pass++;
    total++;
    if (lat !== 9) $display("FAIL %s latency got %0d exp 9", name, lat);
    else pass++;
    total++;
    if (bcnt !== 9) $display("FAIL %s busy_cycles got %0d exp 9", name, bcnt);
    else pass++;
    @(negedge clk);
    total++;
    if (done8 !== 1'b0 || busy8 !== 1'b0)
      $display("FAIL %s after_done done=%b busy=%b exp 0 0", name, done8, busy8);
    else pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 16'h0)
      $display("FAIL reset8 busy=%b done=%b result=%h exp 0 0 0000", busy8, done8, res8);
    else pass++;
    total++;
    if (busy16 !== 1'b0 || done16 !== 1'b0 || res16 !== 32'h0)
      $display("FAIL reset16 busy=%b done=%b result=%h exp 0 0 0", busy16, done16, res16);
    else pass++;
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    check_op8("u13x11", 8'd13, 8'd11, 1'b0);
    check_op8("u255x255", 8'd255, 8'd255, 1'b0);
    check_op8("u0x200", 8'd0, 8'd200, 1'b0);
    for (int i = 0; i < 15; i++) check_op8("urand", 8'($urandom), 8'($urandom), 1'b0);
  endtask

  task automatic test_signed;
    check_op8("sm3x5", 8'hFD, 8'd5, 1'b1);
    check_op8("sm128xm128", 8'h80, 8'h80, 1'b1);
    check_op8("sm128x127", 8'h80, 8'h7F, 1'b1);
    check_op8("szero", 8'h00, 8'hC3, 1'b1);
    for (int i = 0; i < 15; i++) check_op8("srand", 8'($urandom), 8'($urandom), 1'b1);
  endtask

  task automatic test_ignore_start;
    logic [15:0] e;
    int lat, dcount;
    e = ref8(8'd77, 8'd201, 1'b0);
    @(negedge clk);
    a8 = 8'd77; b8 = 8'd201; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    lat = 0; dcount = 0;
    while (!done8 && lat < 40) begin
      if (lat == 3) begin a8 = 8'hFF; b8 = 8'h80; sm8 = 1'b1; start8 = 1'b1; end
      if (lat == 4) start8 = 1'b0;
      @(negedge clk);
      lat++;
    end
    total++;
    if (res8 !== e || lat !== 9) $display("FAIL ignore_start result=%h lat=%0d exp %h 9", res8, lat, e);
    else pass++;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      dcount += int'(done8 | busy8);
    end
    total++;
    if (dcount !== 0) $display("FAIL ignore_start extra_activity got %0d cycles exp 0", dcount);
    else pass++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] e1, e2, r1, r2;
    int d1, d2, dcount;
    e1 = ref8(8'hF0, 8'h0B, 1'b1);
    e2 = ref8(8'h39, 8'hE4, 1'b0);
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h0B; sm8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'h39; b8 = 8'hE4; sm8 = 1'b0;
    d1 = -1; d2 = -1; dcount = 0; r1 = '0; r2 = '0;
    for (int k = 0; k < 40; k++) begin
      if (done8) begin
        dcount++;
        if (dcount == 1) begin d1 = k; r1 = res8; end
        if (dcount == 2) begin d2 = k; r2 = res8; end
      end
      if (dcount == 1 && k == d1 + 1) start8 = 1'b0;
      @(negedge clk);
    end
    total++;
    if (dcount !== 2) $display("FAIL b2b done_pulses got %0d exp 2", dcount);
    else pass++;
    total++;
    if (d1 !== 9 || d2 - d1 !== 10) $display("FAIL b2b timing d1=%0d gap=%0d exp 9 10", d1, d2 - d1);
    else pass++;
    total++;
    if (r1 !== e1 || r2 !== e2) $display("FAIL b2b results got %h %h exp %h %h", r1, r2, e1, e2);
    else pass++;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    a8 = 8'd99; b8 = 8'd99; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 16'h0)
      $display("FAIL reset_mid busy=%b done=%b result=%h exp 0 0 0000", busy8, done8, res8);
    else pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || res8 !== 16'h0) begin
        total++;
        $display("FAIL reset_mid resumed done=%b result=%h exp 0 0000", done8, res8);
      end
    end
    check_op8("after_reset", 8'h9C, 8'h27, 1'b1);
  endtask

  task automatic op16(input logic [15:0] ia, input logic [15:0] ib, input logic is,
                      input logic [31:0] e, input string name);
    int lat;
    @(negedge clk);
    a16 = ia; b16 = ib; sm16 = is; start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 0;
    while (!done16 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (res16 !== e) $display("FAIL %s result got %h exp %h", name, res16, e);
    else pass++;
    total++;
    if (lat !== 17) $display("FAIL %s latency got %0d exp 17", name, lat);
    else pass++;
  endtask

  task automatic test_w16;
    logic [15:0] x, y;
    logic s;
    op16(16'hFB2E, 16'd567, 1'b1, 32'hFFF552E2, "w16_m1234x567");
    op16(16'h8000, 16'h8000, 1'b1, 32'h40000000, "w16_minxmin");
    op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16_umax");
    for (int i = 0; i < 8; i++) begin
      x = 16'($urandom); y = 16'($urandom); s = 1'($urandom);
      op16(x, y, s, ref16(x, y, s), "w16_rand");
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_w16();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
